// File: rtl/birth_disp_pkg.sv
// rtl/birth_disp_pkg.sv - shared 7-segment glyph constants for the birthday scroll display
package birth_disp_pkg;
   localparam int SEG_W = 7;

   // Active-low {g,f,e,d,c,b,a}
   localparam logic [SEG_W-1:0] GLYPH_0   = 7'h40;
   localparam logic [SEG_W-1:0] GLYPH_1   = 7'h79;
   localparam logic [SEG_W-1:0] GLYPH_2   = 7'h24;
   localparam logic [SEG_W-1:0] GLYPH_3   = 7'h30;
   localparam logic [SEG_W-1:0] GLYPH_4   = 7'h19;
   localparam logic [SEG_W-1:0] GLYPH_5   = 7'h12;
   localparam logic [SEG_W-1:0] GLYPH_6   = 7'h02;
   localparam logic [SEG_W-1:0] GLYPH_7   = 7'h58;
   localparam logic [SEG_W-1:0] GLYPH_8   = 7'h00;
   localparam logic [SEG_W-1:0] GLYPH_9   = 7'h10;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD to active-low 7-segment glyph, blanking codes above 9
module seg7_decode
   import birth_disp_pkg::*;
(
   input  logic [3:0]       bcd_i,
   output logic [SEG_W-1:0] seg_o
);
   always_comb begin
      case (bcd_i)
         4'd0:    seg_o = GLYPH_0;
         4'd1:    seg_o = GLYPH_1;
         4'd2:    seg_o = GLYPH_2;
         4'd3:    seg_o = GLYPH_3;
         4'd4:    seg_o = GLYPH_4;
         4'd5:    seg_o = GLYPH_5;
         4'd6:    seg_o = GLYPH_6;
         4'd7:    seg_o = GLYPH_7;
         4'd8:    seg_o = GLYPH_8;
         4'd9:    seg_o = GLYPH_9;
         default: seg_o = SEG_BLANK;
      endcase
   end
endmodule

// File: rtl/birth_scroll_display.sv
// rtl/birth_scroll_display.sv - scrolling window over a BCD digit sequence driving multiplexed 7-segment displays
module birth_scroll_display
   import birth_disp_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int DISP_DIGITS = 4,
   parameter int TICK_DIV    = 50_000_000,
   parameter int SCAN_DIV    = 50_000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [4*NUM_DIGITS-1:0]       seq_data,
   input  logic                          run,
   input  logic                          dir,
   input  logic                          step,
   output logic [$clog2(NUM_DIGITS)-1:0] idx,
   output logic                          wrap,
   output logic [DISP_DIGITS-1:0]        an,
   output logic [SEG_W-1:0]              seg
);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = (DISP_DIGITS > 1) ? $clog2(DISP_DIGITS) : 1;

   logic [IW-1:0]          idx_q, idx_d;
   logic [PW-1:0]          pre_q, pre_d;
   logic [SW-1:0]          sdiv_q, sdiv_d;
   logic [DW-1:0]          sc_q, sc_d;
   logic                   wrap_q, wrap_d;
   logic [DISP_DIGITS-1:0] an_q, an_d;
   logic [SEG_W-1:0]       seg_q, seg_d;

   logic                   pre_tc, adv, sdiv_tc;
   logic [IW:0]            sum;
   logic [IW-1:0]          sel;
   logic [3:0]             digit;
   logic [SEG_W-1:0]       glyph;

   // Prescaler only runs while auto-scrolling; step is the advance source when paused.
   always_comb begin
      pre_tc = (pre_q == PW'(TICK_DIV - 1));
      adv    = run ? pre_tc : step;
      pre_d  = (run && !pre_tc) ? pre_q + PW'(1) : '0;
      idx_d  = idx_q;
      wrap_d = 1'b0;
      if (adv) begin
         if (!dir) begin
            if (idx_q == IW'(NUM_DIGITS - 1)) begin
               idx_d  = '0;
               wrap_d = 1'b1;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end else begin
            if (idx_q == '0) begin
               idx_d  = IW'(NUM_DIGITS - 1);
               wrap_d = 1'b1;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
      end
   end

   // Anode scan runs freely; the window digit is (idx + sc) folded back into range.
   always_comb begin
      sdiv_tc = (sdiv_q == SW'(SCAN_DIV - 1));
      sdiv_d  = sdiv_tc ? '0 : sdiv_q + SW'(1);
      sc_d    = sc_q;
      if (sdiv_tc) begin
         sc_d = (sc_q == DW'(DISP_DIGITS - 1)) ? '0 : sc_q + DW'(1);
      end
      sum = {1'b0, idx_q} + (IW+1)'(sc_q);
      sel = (sum >= (IW+1)'(NUM_DIGITS)) ? IW'(sum - (IW+1)'(NUM_DIGITS)) : sum[IW-1:0];
      digit = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (sel == IW'(k)) begin
            digit = seq_data[4*k +: 4];
         end
      end
      an_d  = ~(DISP_DIGITS'(1) << sc_q);
      seg_d = glyph;
   end

   seg7_decode u_decode (
      .bcd_i (digit),
      .seg_o (glyph)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= '0;
         pre_q  <= '0;
         sdiv_q <= '0;
         sc_q   <= '0;
         wrap_q <= 1'b0;
         an_q   <= '1;
         seg_q  <= SEG_BLANK;
      end else begin
         idx_q  <= idx_d;
         pre_q  <= pre_d;
         sdiv_q <= sdiv_d;
         sc_q   <= sc_d;
         wrap_q <= wrap_d;
         an_q   <= an_d;
         seg_q  <= seg_d;
      end
   end

   assign idx  = idx_q;
   assign wrap = wrap_q;
   assign an   = an_q;
   assign seg  = seg_q;
endmodule

// File: tb/tb_birth_scroll_display.sv
// tb/tb_birth_scroll_display.sv - self-checking bench for birth_scroll_display
module tb_birth_scroll_display;
   localparam int N  = 8;
   localparam int D  = 4;
   localparam int TD = 4;
   localparam int SD = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [4*N-1:0] seq_data;
   logic          run, dir, step;
   logic [2:0]    idx;
   logic          wrap;
   logic [D-1:0]  an;
   logic [6:0]    seg;

   always #5 clk = ~clk;

   birth_scroll_display #(
      .NUM_DIGITS  (N),
      .DISP_DIGITS (D),
      .TICK_DIV    (TD),
      .SCAN_DIV    (SD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .seq_data (seq_data),
      .run      (run),
      .dir      (dir),
      .step     (step),
      .idx      (idx),
      .wrap     (wrap),
      .an       (an),
      .seg      (seg)
   );

   typedef struct packed {
      logic [2:0] idx;
      logic       wrap;
      logic [3:0] an;
      logic [6:0] seg;
   } exp_t;

   typedef struct {
      logic run;
      logic dir;
      logic step;
      int   cycles;
      int   exp_idx;
      int   exp_wraps;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[20];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   wrap_cnt = 0;

   int         m_idx = 0, m_pre = 0, m_sc = 0, m_sdiv = 0;
   logic       m_wrap = 1'b0;
   logic [3:0] m_an = 4'hF;
   logic [6:0] m_seg = 7'h7F;

   logic [6:0] exp_seg5 [4];
   logic [6:0] exp_segc [4];

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h58;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      int  dg;
      bit  adv;
      if (rst) begin
         m_idx = 0; m_pre = 0; m_sc = 0; m_sdiv = 0;
         m_wrap = 1'b0; m_an = 4'hF; m_seg = 7'h7F;
      end else begin
         dg    = (m_idx + m_sc) % N;
         m_an  = 4'hF ^ (4'h1 << m_sc);
         m_seg = glyph(seq_data[4*dg +: 4]);
         adv   = run ? (m_pre == TD - 1) : step;
         m_wrap = 1'b0;
         if (adv) begin
            if (!dir) begin
               m_wrap = (m_idx == N - 1);
               m_idx  = (m_idx + 1) % N;
            end else begin
               m_wrap = (m_idx == 0);
               m_idx  = (m_idx + N - 1) % N;
            end
         end
         m_pre = (run && m_pre != TD - 1) ? m_pre + 1 : 0;
         if (m_sdiv == SD - 1) begin
            m_sdiv = 0;
            m_sc   = (m_sc + 1) % D;
         end else begin
            m_sdiv = m_sdiv + 1;
         end
      end
   endtask

   task automatic cycle();
      exp_t e;
      model_step();
      e.idx  = 3'(m_idx);
      e.wrap = m_wrap;
      e.an   = m_an;
      e.seg  = m_seg;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      n_chk++;
      if ({idx, wrap, an, seg} !== e) begin
         n_fail++;
         $display("FAIL sb cycle %0d: got idx=%0d wrap=%b an=%h seg=%h expected idx=%0d wrap=%b an=%h seg=%h",
                  cyc, idx, wrap, an, seg, e.idx, e.wrap, e.an, e.seg);
      end
      if (wrap === 1'b1) wrap_cnt++;
      cyc++;
   endtask

   task automatic do_step(input logic d);
      dir  = d;
      step = 1'b1;
      cycle();
      step = 1'b0;
      cycle();
   endtask

   initial begin
      // run, dir, step, cycles, idx afterwards, wrap pulses seen
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 40, 2, 1};
      vecs[1]  = '{1'b0, 1'b1, 1'b0,  3, 2, 0};
      vecs[2]  = '{1'b0, 1'b1, 1'b1,  1, 1, 0};
      vecs[3]  = '{1'b0, 1'b1, 1'b0,  1, 1, 0};
      vecs[4]  = '{1'b0, 1'b1, 1'b1,  1, 0, 0};
      vecs[5]  = '{1'b0, 1'b1, 1'b0,  2, 0, 0};
      vecs[6]  = '{1'b0, 1'b1, 1'b1,  1, 7, 1};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 20, 7, 0};
      vecs[8]  = '{1'b0, 1'b0, 1'b1,  1, 0, 1};
      vecs[9]  = '{1'b0, 1'b0, 1'b0,  1, 0, 0};
      vecs[10] = '{1'b1, 1'b0, 1'b0,  2, 0, 0};
      vecs[11] = '{1'b1, 1'b0, 1'b1,  1, 0, 0};
      vecs[12] = '{1'b1, 1'b0, 1'b0,  1, 1, 0};
      vecs[13] = '{1'b1, 1'b0, 1'b0,  2, 1, 0};
      vecs[14] = '{1'b0, 1'b0, 1'b0,  1, 1, 0};
      vecs[15] = '{1'b1, 1'b0, 1'b0,  3, 1, 0};
      vecs[16] = '{1'b1, 1'b0, 1'b0,  1, 2, 0};
      vecs[17] = '{1'b0, 1'b0, 1'b1,  1, 3, 0};
      vecs[18] = '{1'b1, 1'b1, 1'b0,  8, 1, 0};
      vecs[19] = '{1'b1, 1'b1, 1'b0,  8, 7, 1};
      exp_seg5[0] = 7'h00; exp_seg5[1] = 7'h79; exp_seg5[2] = 7'h58; exp_seg5[3] = 7'h24;
      exp_segc[0] = 7'h24; exp_segc[1] = 7'h40; exp_segc[2] = 7'h40; exp_segc[3] = 7'h7F;

      seq_data = 32'h7180_5002;
      rst = 1'b1; run = 1'b0; dir = 1'b0; step = 1'b0;
      repeat (3) cycle();
      check("reset_an", an, 4'hF);
      check("reset_seg", seg, 7'h7F);
      check("reset_idx", idx, 0);
      check("reset_wrap", wrap, 0);

      rst = 1'b0;
      cycle();
      check("first_slot_an", an, 4'hE);
      check("first_slot_seg", seg, 7'h24);

      for (int v = 0; v < 20; v++) begin
         run = vecs[v].run;
         dir = vecs[v].dir;
         step = vecs[v].step;
         wrap_cnt = 0;
         for (int c = 0; c < vecs[v].cycles; c++) cycle();
         step = 1'b0;
         check($sformatf("vec%0d_idx", v), idx, vecs[v].exp_idx);
         check($sformatf("vec%0d_wraps", v), wrap_cnt, vecs[v].exp_wraps);
      end

      // Window starting at idx 5 crosses the end of the sequence.
      run = 1'b0;
      do_step(1'b1);
      do_step(1'b1);
      check("idx_at_5", idx, 5);
      for (int c = 0; c < 8; c++) begin
         cycle();
         for (int d = 0; d < D; d++)
            if (an[d] == 1'b0) check($sformatf("scan5_d%0d", d), seg, exp_seg5[d]);
      end

      // Non-BCD digit blanks only its own display.
      do_step(1'b0);
      do_step(1'b0);
      do_step(1'b0);
      check("idx_at_0", idx, 0);
      seq_data = 32'h7180_C002;
      repeat (2) cycle();
      for (int c = 0; c < 8; c++) begin
         cycle();
         for (int d = 0; d < D; d++)
            if (an[d] == 1'b0) check($sformatf("blank_d%0d", d), seg, exp_segc[d]);
      end
      seq_data = 32'h7180_5002;

      // Reset in the middle of auto-scrolling.
      for (int s = 0; s < 4; s++) do_step(1'b0);
      check("idx_at_4", idx, 4);
      run = 1'b1;
      repeat (2) cycle();
      rst = 1'b1;
      cycle();
      check("midrst_idx", idx, 0);
      check("midrst_an", an, 4'hF);
      check("midrst_seg", seg, 7'h7F);
      check("midrst_wrap", wrap, 0);
      rst = 1'b0;
      repeat (3) cycle();
      check("restart_hold_idx", idx, 0);
      cycle();
      check("restart_adv_idx", idx, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
